ps2_keycode: RTL and testbench



---
 rtl/ps2_keycode_pkg.sv | 66 ++++++
 rtl/ps2_keycode_if.sv | 16 +
 rtl/ps2_keycode_rx.sv | 92 +++++++++
 rtl/ps2_keycode.sv | 74 +++++++
 tb/tb_ps2_keycode.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keycode_pkg.sv
// ps2_keycode_pkg: shared state enums, scan-code/keycode constants and the set-2 -> HID translation.
//   rx_state_t  : receiver FSM states (one per bit class)
//   dec_state_t : prefix decoder states
//   map_t       : translation result {hit, code}
//   map_code    : (extended prefix seen, set-2 byte) -> map_t
package ps2_keycode_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam logic [15:0] KEY_NONE  = 16'h0000;
    localparam logic [15:0] KEY_UP    = 16'h0052;
    localparam logic [15:0] KEY_DOWN  = 16'h0051;
    localparam logic [15:0] KEY_RIGHT = 16'h004F;
    localparam logic [15:0] KEY_LEFT  = 16'h0050;
    localparam logic [15:0] KEY_W     = 16'h001A;
    localparam logic [15:0] KEY_A     = 16'h0004;
    localparam logic [15:0] KEY_S     = 16'h0016;
    localparam logic [15:0] KEY_D     = 16'h0007;
    localparam logic [15:0] KEY_SPACE = 16'h002C;
    localparam logic [15:0] KEY_ENTER = 16'h0028;

    typedef struct packed {
        logic        hit;
        logic [15:0] code;
    } map_t;

    function automatic map_t map_code(input logic ext, input logic [7:0] sc);
        map_t m;
        m = '{hit: 1'b1, code: KEY_NONE};
        if (ext) begin
            case (sc)
                SC_UP:    m.code = KEY_UP;
                SC_DOWN:  m.code = KEY_DOWN;
                SC_RIGHT: m.code = KEY_RIGHT;
                SC_LEFT:  m.code = KEY_LEFT;
                default:  m.hit  = 1'b0;
            endcase
        end else begin
            case (sc)
                SC_W:     m.code = KEY_W;
                SC_A:     m.code = KEY_A;
                SC_S:     m.code = KEY_S;
                SC_D:     m.code = KEY_D;
                SC_SPACE: m.code = KEY_SPACE;
                SC_ENTER: m.code = KEY_ENTER;
                default:  m.hit  = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_keycode_if.sv
// ps2_keycode_if: keyboard pins plus keycode outputs.
//   PS2_Clk, PS2_Data : keyboard clock/data pins (driven by master)
//   CodeKey           : current keycode, 0x0000 when no mapped key held
//   KeyValid          : one-cycle pulse when CodeKey changes
//   FrameErr          : one-cycle pulse on a bad or aborted frame
//   master = keyboard/consumer side, slave = decoder
interface ps2_keycode_if;
    logic        PS2_Clk;
    logic        PS2_Data;
    logic [15:0] CodeKey;
    logic        KeyValid;
    logic        FrameErr;

    modport master (output PS2_Clk, PS2_Data, input CodeKey, KeyValid, FrameErr);
    modport slave  (input PS2_Clk, PS2_Data, output CodeKey, KeyValid, FrameErr);
endinterface

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 frame receiver with input synchronizers, falling-edge detect and timeout.
//   Clk, Reset_n : system clock, async active-low reset
//   PS2_Clk/Data : asynchronous keyboard pins
//   rx_byte      : received byte, valid while byte_stb is high
//   byte_stb     : one-cycle pulse, cycle after the stop-bit edge of a good frame
//   frame_err    : one-cycle pulse on start/parity/stop error or timeout
module ps2_keycode_rx
    import ps2_keycode_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_Clk,
    input  logic       PS2_Data,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] ck_sync, d_sync;
    logic                   ck_prev;
    rx_state_t              state;
    logic [3:0]             cnt;
    logic                   par;
    logic [TW-1:0]          tmo;

    wire ck_s = ck_sync[SYNC_STAGES-1];
    wire d_s  = d_sync[SYNC_STAGES-1];
    wire fall = ck_prev & ~ck_s;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ck_sync   <= '1;
            d_sync    <= '1;
            ck_prev   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            par       <= 1'b0;
            rx_byte   <= '0;
            tmo       <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ck_sync   <= {ck_sync[SYNC_STAGES-2:0], PS2_Clk};
            d_sync    <= {d_sync[SYNC_STAGES-2:0], PS2_Data};
            ck_prev   <= ck_s;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            // Timeout wins over a coincident edge: the frame is already stale.
            if (state != RX_IDLE && tmo == TMO_MAX) begin
                frame_err <= 1'b1;
                state     <= RX_IDLE;
                tmo       <= '0;
            end else if (fall) begin
                tmo <= '0;
                case (state)
                    RX_IDLE: begin
                        if (d_s) begin
                            frame_err <= 1'b1;
                        end else begin
                            state <= RX_DATA;
                            cnt   <= '0;
                        end
                    end
                    RX_DATA: begin
                        rx_byte <= {d_s, rx_byte[7:1]};
                        cnt     <= cnt + 4'd1;
                        if (cnt == 4'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par   <= d_s;
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        // Odd parity: data bits plus parity bit must XOR to 1.
                        if (d_s && (^{rx_byte, par})) byte_stb <= 1'b1;
                        else frame_err <= 1'b1;
                        state <= RX_IDLE;
                    end
                endcase
            end else if (state != RX_IDLE) begin
                tmo <= tmo + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode.sv
// ps2_keycode: PS/2 set-2 keyboard to HID keycode for the ball logic.
//   Clk, Reset_n : 50 MHz system clock, async active-low reset
//   bus.PS2_Clk/PS2_Data : keyboard pins
//   bus.CodeKey  : currently held mapped key, 0x0000 when none
//   bus.KeyValid : one-cycle pulse when CodeKey changes
//   bus.FrameErr : one-cycle pulse on a bad or aborted frame
module ps2_keycode
    import ps2_keycode_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input logic          Clk,
    input logic          Reset_n,
    ps2_keycode_if.slave bus
);

    logic [7:0]  rx_byte;
    logic        byte_stb;
    logic        frame_err;
    dec_state_t  dstate;
    logic [15:0] code;
    logic        key_valid;

    ps2_keycode_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .PS2_Clk  (bus.PS2_Clk),
        .PS2_Data (bus.PS2_Data),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .frame_err(frame_err)
    );

    wire  ext = (dstate == D_EXT) || (dstate == D_EXT_BRK);
    wire  brk = (dstate == D_BRK) || (dstate == D_EXT_BRK);
    map_t m;

    always_comb m = map_code(ext, rx_byte);

    // Prefix bytes never map, so only the state update needs to know about them.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dstate    <= D_BASE;
            code      <= KEY_NONE;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_stb) begin
                case (dstate)
                    D_BASE:  dstate <= (rx_byte == SC_EXT) ? D_EXT : (rx_byte == SC_BRK) ? D_BRK : D_BASE;
                    D_EXT:   dstate <= (rx_byte == SC_BRK) ? D_EXT_BRK : (rx_byte == SC_EXT) ? D_EXT : D_BASE;
                    default: dstate <= D_BASE;
                endcase
                if (m.hit && !brk && m.code != code) begin
                    code      <= m.code;
                    key_valid <= 1'b1;
                end
                if (m.hit && brk && m.code == code) begin
                    code      <= KEY_NONE;
                    key_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.CodeKey  = code;
    assign bus.KeyValid = key_valid;
    assign bus.FrameErr = frame_err;

endmodule

// File: tb/tb_ps2_keycode.sv
// tb_ps2_keycode: randomized and directed bench for ps2_keycode against a behavioural key model.
module tb_ps2_keycode;

    localparam int H   = 10;
    localparam int TMO = 50000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    int          kv_cnt = 0;
    int          fe_cnt = 0;
    int          exp_kv = 0;
    int          exp_fe = 0;
    logic [15:0] cur = 16'h0000;
    bit          m_ext = 0;
    bit          m_brk = 0;

    ps2_keycode_if ps();

    ps2_keycode #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .Clk    (clk),
        .Reset_n(rst_n),
        .bus    (ps.slave)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (ps.KeyValid === 1'b1) kv_cnt++;
        if (ps.FrameErr === 1'b1) fe_cnt++;
    end

    function automatic logic [16:0] ref_map(input bit e, input logic [7:0] b);
        case ({e, b})
            {1'b1, 8'h75}: return {1'b1, 16'h0052};
            {1'b1, 8'h72}: return {1'b1, 16'h0051};
            {1'b1, 8'h74}: return {1'b1, 16'h004F};
            {1'b1, 8'h6B}: return {1'b1, 16'h0050};
            {1'b0, 8'h1D}: return {1'b1, 16'h001A};
            {1'b0, 8'h1C}: return {1'b1, 16'h0004};
            {1'b0, 8'h1B}: return {1'b1, 16'h0016};
            {1'b0, 8'h23}: return {1'b1, 16'h0007};
            {1'b0, 8'h29}: return {1'b1, 16'h002C};
            {1'b0, 8'h5A}: return {1'b1, 16'h0028};
            default:       return 17'h0;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [16:0] mm;
        mm = ref_map(m_ext, b);
        if (m_brk) begin
            if (mm[16] && mm[15:0] == cur) begin
                cur = 16'h0000;
                exp_kv++;
            end
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (mm[16] && mm[15:0] != cur) begin
                cur = mm[15:0];
                exp_kv++;
            end
            m_ext = 0;
        end
    endtask

    task automatic model_reset();
        cur   = 16'h0000;
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps.PS2_Data = f[i];
            repeat (H) @(negedge clk);
            ps.PS2_Clk = 1'b0;
            repeat (H) @(negedge clk);
            ps.PS2_Clk = 1'b1;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input bit bad);
        if (bad) exp_fe++;
        else model_byte(b);
        send_frame(b, bad, 11);
        repeat (2 * H) @(negedge clk);
        ps.PS2_Data = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ps.PS2_Clk = 1'b1;
        ps.PS2_Data = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++;
        if (ps.CodeKey !== 16'h0000 || ps.KeyValid !== 1'b0 || ps.FrameErr !== 1'b0)
            begin n_err++; $display("FAIL reset: code=%h kv=%b fe=%b, need 0000/0/0", ps.CodeKey, ps.KeyValid, ps.FrameErr); end
        rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_latency();
        logic [15:0] old;
        xfer(8'hE0, 0);
        old = cur;
        model_byte(8'h75);
        send_frame(8'h75, 0, 10);
        ps.PS2_Data = 1'b1;
        repeat (H) @(negedge clk);
        ps.PS2_Clk = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (ps.CodeKey !== old) begin n_err++; $display("FAIL lat_early: code=%h, need %h", ps.CodeKey, old); end
        @(negedge clk);
        n_chk++;
        if (ps.CodeKey !== cur || ps.KeyValid !== 1'b1)
            begin n_err++; $display("FAIL lat_code: code=%h kv=%b, need %h/1", ps.CodeKey, ps.KeyValid, cur); end
        @(negedge clk);
        n_chk++;
        if (ps.KeyValid !== 1'b0) begin n_err++; $display("FAIL lat_pulse: kv=%b, need 0", ps.KeyValid); end
        repeat (H - 5) @(negedge clk);
        ps.PS2_Clk = 1'b1;
        repeat (2 * H) @(negedge clk);
        n_chk++;
        if (kv_cnt !== exp_kv || cur !== 16'h0052)
            begin n_err++; $display("FAIL lat_count: kv=%0d model=%h, need %0d/0052", kv_cnt, cur, exp_kv); end
    endtask

    task automatic test_typematic();
        for (int i = 0; i < 3; i++) begin
            xfer(8'hE0, 0);
            xfer(8'h75, 0);
        end
        n_chk++;
        if (ps.CodeKey !== 16'h0052 || kv_cnt !== exp_kv)
            begin n_err++; $display("FAIL typematic: code=%h kv=%0d, need 0052/%0d", ps.CodeKey, kv_cnt, exp_kv); end
        xfer(8'hE0, 0);
        xfer(8'hF0, 0);
        xfer(8'h75, 0);
        n_chk++;
        if (ps.CodeKey !== 16'h0000 || kv_cnt !== exp_kv)
            begin n_err++; $display("FAIL ext_break: code=%h kv=%0d, need 0000/%0d", ps.CodeKey, kv_cnt, exp_kv); end
    endtask

    task automatic test_wasd();
        int kv0;
        kv0 = kv_cnt;
        xfer(8'h1D, 0);
        n_chk++;
        if (ps.CodeKey !== 16'h001A) begin n_err++; $display("FAIL w_make: code=%h, need 001a", ps.CodeKey); end
        xfer(8'h1C, 0);
        xfer(8'hF0, 0);
        xfer(8'h1D, 0);
        n_chk++;
        if (ps.CodeKey !== 16'h0004 || kv_cnt - kv0 !== 2)
            begin n_err++; $display("FAIL w_break_other: code=%h pulses=%0d, need 0004/2", ps.CodeKey, kv_cnt - kv0); end
    endtask

    task automatic test_errors();
        logic [15:0] old;
        old = cur;
        xfer(8'h72, 1);
        n_chk++;
        if (ps.CodeKey !== old || fe_cnt !== exp_fe)
            begin n_err++; $display("FAIL parity: code=%h fe=%0d, need %h/%0d", ps.CodeKey, fe_cnt, old, exp_fe); end
        ps.PS2_Data = 1'b1;
        repeat (H) @(negedge clk);
        ps.PS2_Clk = 1'b0;
        repeat (H) @(negedge clk);
        ps.PS2_Clk = 1'b1;
        repeat (H) @(negedge clk);
        exp_fe++;
        n_chk++;
        if (fe_cnt !== exp_fe) begin n_err++; $display("FAIL start_bit: fe=%0d, need %0d", fe_cnt, exp_fe); end
        xfer(8'hE0, 0);
        xfer(8'h72, 0);
        n_chk++;
        if (ps.CodeKey !== 16'h0051 || kv_cnt !== exp_kv)
            begin n_err++; $display("FAIL after_err: code=%h kv=%0d, need 0051/%0d", ps.CodeKey, kv_cnt, exp_kv); end
    endtask

    task automatic test_timeout();
        int k;
        send_frame(8'h6B, 0, 5);
        k = H;
        do begin
            @(negedge clk);
            k++;
        end while (ps.FrameErr !== 1'b1 && k < TMO + 200);
        exp_fe++;
        n_chk++;
        if (k !== TMO + 4) begin n_err++; $display("FAIL timeout_time: err after %0d cycles, need %0d", k, TMO + 4); end
        repeat (5) @(negedge clk);
        n_chk++;
        if (fe_cnt !== exp_fe) begin n_err++; $display("FAIL timeout_pulse: fe=%0d, need %0d", fe_cnt, exp_fe); end
        xfer(8'hE0, 0);
        xfer(8'h6B, 0);
        n_chk++;
        if (ps.CodeKey !== 16'h0050 || fe_cnt !== exp_fe)
            begin n_err++; $display("FAIL after_timeout: code=%h fe=%0d, need 0050/%0d", ps.CodeKey, fe_cnt, exp_fe); end
    endtask

    task automatic test_reset_mid();
        xfer(8'hE0, 0);
        xfer(8'h74, 0);
        n_chk++;
        if (ps.CodeKey !== 16'h004F) begin n_err++; $display("FAIL right_make: code=%h, need 004f", ps.CodeKey); end
        send_frame(8'h72, 0, 4);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ps.CodeKey !== 16'h0000 || ps.KeyValid !== 1'b0)
            begin n_err++; $display("FAIL async_reset: code=%h kv=%b, need 0000/0", ps.CodeKey, ps.KeyValid); end
        model_reset();
        ps.PS2_Data = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        xfer(8'hE0, 0);
        xfer(8'h74, 0);
        n_chk++;
        if (ps.CodeKey !== 16'h004F || kv_cnt !== exp_kv || fe_cnt !== exp_fe)
            begin n_err++; $display("FAIL after_reset: code=%h kv=%0d fe=%0d, need 004f/%0d/%0d", ps.CodeKey, kv_cnt, exp_kv, fe_cnt, exp_fe); end
    endtask

    task automatic test_random();
        logic [7:0] pool [13];
        logic [7:0] b;
        bit         bad;
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h74, 8'h6B, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h00};
        for (int i = 0; i < 30; i++) begin
            b = pool[$urandom_range(0, 12)];
            if (b == 8'h00) b = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            xfer(b, bad);
            n_chk++;
            if (ps.CodeKey !== cur || kv_cnt !== exp_kv || fe_cnt !== exp_fe)
                begin n_err++; $display("FAIL random[%0d] byte=%h bad=%b: code=%h kv=%0d fe=%0d, need %h/%0d/%0d", i, b, bad, ps.CodeKey, kv_cnt, fe_cnt, cur, exp_kv, exp_fe); end
        end
    endtask

    initial begin
        ps.PS2_Clk  = 1'b1;
        ps.PS2_Data = 1'b1;
        test_reset();
        test_latency();
        test_typematic();
        test_wasd();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
